// File: rtl/ps2_poly_tone.sv
// Polyphonic square-wave tone generator fed by the raw PS/2 scancode stream.
// Optional macro PS2_POLY_TONE_SAT_EN: saturate the voice mix instead of wrapping.

module ps2_poly_tone_voice #(
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic [7:0]       new_code,
  input  logic [CNT_W-1:0] new_half,
  output logic             active,
  output logic             phase,
  output logic [7:0]       code
);
  logic [CNT_W-1:0] cnt, half;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active <= 1'b0;
      phase  <= 1'b1;
      code   <= '0;
      cnt    <= '0;
      half   <= '0;
    end else if (load) begin
      active <= 1'b1;
      phase  <= 1'b1;
      code   <= new_code;
      half   <= new_half;
      cnt    <= '0;
    end else if (clear) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (active) begin
      if (cnt == half) begin
        cnt   <= '0;
        phase <= ~phase;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module ps2_poly_tone #(
  parameter int VOICES   = 4,
  parameter int SAMPLE_W = 32,
  parameter int AMP      = 10000000,
  parameter int CNT_W    = 19
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          received_data,
  input  logic                received_data_en,
  output logic [SAMPLE_W-1:0] sound,
  output logic [VOICES-1:0]   voice_active,
  output logic                note_dropped
);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

  localparam logic signed [SAMPLE_W+2:0] AMP_X   = (SAMPLE_W+3)'(AMP);
  localparam logic signed [SAMPLE_W+2:0] SAT_MAX = {4'b0000, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [SAMPLE_W+2:0] SAT_MIN = {4'b1111, {(SAMPLE_W-1){1'b0}}};

  state_t                  state, state_nxt;
  logic                    make_req, rel_req;
  logic                    rom_hit;
  logic [19:0]             rom_val;
  logic [CNT_W-1:0]        rom_half;
  logic [VOICES-1:0]       act, ph, held, load, clear;
  logic [VOICES-1:0][7:0]  code;
  logic                    found, alloc, drop;
  logic signed [SAMPLE_W+2:0] sum, mix;

  always_comb begin
    rom_hit = 1'b1;
    rom_val = '0;
    case (received_data)
      8'h15: rom_val = 20'h2F691;
      8'h1D: rom_val = 20'h29AB2;
      8'h24: rom_val = 20'h24A26;
      8'h2D: rom_val = 20'h230E4;
      8'h2C: rom_val = 20'h1F240;
      8'h35: rom_val = 20'h1B6A4;
      8'h3C: rom_val = 20'h18CB7;
      8'h43: rom_val = 20'h17544;
      8'h44: rom_val = 20'h14C8B;
      8'h4D: rom_val = 20'h12843;
      8'h1E: rom_val = 20'h2C0A2;
      8'h26: rom_val = 20'h273C2;
      8'h2E: rom_val = 20'h20FE1;
      8'h36: rom_val = 20'h1D649;
      8'h3D: rom_val = 20'h1A2FA;
      8'h46: rom_val = 20'h16051;
      8'h45: rom_val = 20'h139E1;
      default: rom_hit = 1'b0;
    endcase
    rom_half = CNT_W'(rom_val);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Extended (E0-prefixed) sequences are swallowed so those keys never sound.
  always_comb begin
    state_nxt = state;
    make_req  = 1'b0;
    rel_req   = 1'b0;
    if (received_data_en) begin
      case (state)
        IDLE: begin
          if (received_data == 8'hF0)      state_nxt = BRK;
          else if (received_data == 8'hE0) state_nxt = EXT;
          else                             make_req  = rom_hit;
        end
        BRK: begin
          rel_req   = 1'b1;
          state_nxt = IDLE;
        end
        EXT:     state_nxt = (received_data == 8'hF0) ? EXT_BRK : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < VOICES; i++)
      held[i] = act[i] && (code[i] == received_data);
    alloc = make_req && !(|held);
    drop  = alloc && (&act);
    clear = rel_req ? held : '0;
    load  = '0;
    found = 1'b0;
    for (int i = 0; i < VOICES; i++) begin
      if (!act[i] && !found) begin
        load[i] = alloc;
        found   = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < VOICES; g++) begin : g_voice
    ps2_poly_tone_voice #(.CNT_W(CNT_W)) u_voice (
      .clk      (CLOCK_50),
      .rst_n    (resetn),
      .load     (load[g]),
      .clear    (clear[g]),
      .new_code (received_data),
      .new_half (rom_half),
      .active   (act[g]),
      .phase    (ph[g]),
      .code     (code[g])
    );
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < VOICES; i++)
      if (act[i]) sum = ph[i] ? sum + AMP_X : sum - AMP_X;
`ifdef PS2_POLY_TONE_SAT_EN
    if (sum > SAT_MAX)      mix = SAT_MAX;
    else if (sum < SAT_MIN) mix = SAT_MIN;
    else                    mix = sum;
`else
    mix = sum;
`endif
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sound        <= '0;
      note_dropped <= 1'b0;
    end else begin
      sound        <= mix[SAMPLE_W-1:0];
      note_dropped <= note_dropped | drop;
    end
  end

  assign voice_active = act;
endmodule

// File: tb/tb_ps2_poly_tone.sv
// Randomized scoreboard bench: a cycle-count reference model predicts outputs of two DUTs
// (default AMP and AMP=2^30) every cycle; a monitor pops and compares on the falling edge.
module tb_ps2_poly_tone;
  localparam int V  = 4;
  localparam longint A1 = 10000000;
  localparam longint A2 = longint'(1) << 30;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rd = '0;
  logic        en = 1'b0;
  logic [31:0] sound1, sound2;
  logic [V-1:0] va1, va2;
  logic        nd1, nd2;

  ps2_poly_tone #(.VOICES(V), .SAMPLE_W(32), .AMP(10000000), .CNT_W(19)) dut1 (
    .CLOCK_50(clk), .resetn(resetn), .received_data(rd), .received_data_en(en),
    .sound(sound1), .voice_active(va1), .note_dropped(nd1));
  ps2_poly_tone #(.VOICES(V), .SAMPLE_W(32), .AMP(1 << 30), .CNT_W(19)) dut2 (
    .CLOCK_50(clk), .resetn(resetn), .received_data(rd), .received_data_en(en),
    .sound(sound2), .voice_active(va2), .note_dropped(nd2));

  always #5 clk = ~clk;

  typedef struct { logic [V-1:0] va; logic nd; logic [31:0] s1; logic [31:0] s2; } exp_t;
  exp_t q[$];

  int rom[byte];
  byte keys[17] = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44,
                    8'h4D, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3D, 8'h46, 8'h45};

  // Reference model state: which voices hold which key and when they were struck.
  bit     m_act[V];
  byte    m_code[V];
  longint m_half[V];
  longint m_start[V];
  bit     m_drop, f0p, e0p;
  longint cyc = 0;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  function automatic logic [31:0] narrow(longint s);
`ifdef PS2_POLY_TONE_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7FFFFFFF;
    if (s < -64'sd2147483648) return 32'h80000000;
`endif
    return s[31:0];
  endfunction

  task automatic model_reset();
    for (int v = 0; v < V; v++) begin
      m_act[v] = 0; m_code[v] = 0; m_half[v] = 0; m_start[v] = 0;
    end
    m_drop = 0; f0p = 0; e0p = 0;
  endtask

  always @(posedge clk) begin
    exp_t   e;
    longint s1, s2, m;
    bit     pos, dup, placed;
    byte    b;
    cyc++;
    s1 = 0; s2 = 0;
    if (!resetn) begin
      model_reset();
    end else begin
      // Output sound reflects voice state as it stood after the previous edge.
      for (int v = 0; v < V; v++) begin
        if (m_act[v]) begin
          m = cyc - 1 - m_start[v];
          pos = ((m / (m_half[v] + 1)) % 2) == 0;
          s1 += pos ? A1 : -A1;
          s2 += pos ? A2 : -A2;
        end
      end
      if (en) begin
        b = rd;
        if (f0p) begin
          if (!e0p)
            for (int v = 0; v < V; v++) if (m_act[v] && m_code[v] == b) m_act[v] = 0;
          f0p = 0; e0p = 0;
        end else if (e0p) begin
          if (b == 8'hF0) f0p = 1; else e0p = 0;
        end else if (b == 8'hF0) f0p = 1;
        else if (b == 8'hE0) e0p = 1;
        else if (rom.exists(b)) begin
          dup = 0; placed = 0;
          for (int v = 0; v < V; v++) if (m_act[v] && m_code[v] == b) dup = 1;
          if (!dup) begin
            for (int v = 0; v < V; v++) begin
              if (!m_act[v] && !placed) begin
                m_act[v] = 1; m_code[v] = b; m_half[v] = rom[b]; m_start[v] = cyc;
                placed = 1;
              end
            end
            if (!placed) m_drop = 1;
          end
        end
      end
    end
    for (int v = 0; v < V; v++) e.va[v] = m_act[v];
    e.nd = m_drop;
    e.s1 = narrow(s1);
    e.s2 = narrow(s2);
    q.push_back(e);
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 20)
        $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("voice_active", 32'(va1), 32'(e.va));
      chk("note_dropped", 32'(nd1), 32'(e.nd));
      chk("sound", sound1, e.s1);
      chk("sound_amp2p30", sound2, e.s2);
    end
  end

  task automatic send(byte b);
    @(negedge clk); #1 rd = b; en = 1'b1;
    @(negedge clk); #1 en = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk); #1 resetn = 1'b0;
    @(negedge clk); #1 resetn = 1'b1;
  endtask

  initial begin
    byte b;
    int  r;
    rom[8'h15] = 'h2F691; rom[8'h1D] = 'h29AB2; rom[8'h24] = 'h24A26; rom[8'h2D] = 'h230E4;
    rom[8'h2C] = 'h1F240; rom[8'h35] = 'h1B6A4; rom[8'h3C] = 'h18CB7; rom[8'h43] = 'h17544;
    rom[8'h44] = 'h14C8B; rom[8'h4D] = 'h12843; rom[8'h1E] = 'h2C0A2; rom[8'h26] = 'h273C2;
    rom[8'h2E] = 'h20FE1; rom[8'h36] = 'h1D649; rom[8'h3D] = 'h1A2FA; rom[8'h46] = 'h16051;
    rom[8'h45] = 'h139E1;
    repeat (3) @(negedge clk);
    #1 resetn = 1'b1;

    // single note on/off
    send(8'h15); idle(20); send(8'hF0); send(8'h15); idle(5);
    // chord and partial release
    send(8'h15); send(8'h1D); send(8'h24); idle(3); send(8'hF0); send(8'h1D); idle(5);
    do_reset();
    // voice exhaustion, release of dropped key
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D); idle(10);
    send(8'h2C); send(8'hF0); send(8'h2C); idle(5);
    do_reset();
    // extended keys and unmapped code never sound
    send(8'hE0); send(8'h15); send(8'hE0); send(8'hF0); send(8'h15); send(8'h1C);
    idle(3); send(8'h15); idle(5);
    // pending F0 forgotten across reset
    send(8'hF0); do_reset(); send(8'h15); idle(5); send(8'hF0); send(8'h15); idle(3);
    do_reset();

    // randomized byte stream
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      b = keys[$urandom_range(0, 16)];
      else if (r < 85) b = 8'hF0;
      else if (r < 92) b = 8'hE0;
      else             b = byte'($urandom_range(0, 255));
      send(b);
      idle($urandom_range(0, 20));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    // long hold with typematic repeats across the first phase toggle of 4D
    do_reset();
    send(8'h4D); send(8'h15);
    for (int i = 0; i < 78; i++) begin
      idle(1000);
      send(8'h4D);
    end
    idle(50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
